// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings, constants and decoder for alu_ctrl_seq
//
// Purpose : Ctrl op encodings, Aluop/Func constants, sequencer state enum,
//           and the Aluop/Func -> Ctrl decode function.
// Ports   : none (package)
// Config  : ALU_MULDIV_EN is resolved by the caller through the
//           muldiv_en argument of decode_ctrl.
package alu_pkg;

  typedef enum logic [3:0] {
    CTRL_NOP  = 4'd0,
    CTRL_ADD  = 4'd1,
    CTRL_SUB  = 4'd2,
    CTRL_AND  = 4'd3,
    CTRL_NOR  = 4'd4,
    CTRL_SLL  = 4'd5,
    CTRL_SLT  = 4'd6,
    CTRL_MULT = 4'd7,
    CTRL_DIVU = 4'd8,
    CTRL_MFHI = 4'd9,
    CTRL_MFLO = 4'd10
  } ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  localparam logic [2:0] ALUOP_RTYPE = 3'b000;
  localparam logic [2:0] ALUOP_LW    = 3'b001;
  localparam logic [2:0] ALUOP_SW    = 3'b010;
  localparam logic [2:0] ALUOP_ANDI  = 3'b011;

  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_NOR  = 6'b100111;
  localparam logic [5:0] FUNC_SLL  = 6'b000000;
  localparam logic [5:0] FUNC_SLT  = 6'b101010;
  localparam logic [5:0] FUNC_MULT = 6'b011000;
  localparam logic [5:0] FUNC_DIVU = 6'b011010;
  localparam logic [5:0] FUNC_MFHI = 6'b010000;
  localparam logic [5:0] FUNC_MFLO = 6'b010010;

  // Aluop 1xx is the branch-compare class; everything below that only
  // needs Func for the R-type class. Unknown Func yields CTRL_NOP, which
  // the sequencer reports as Illegal.
  function automatic ctrl_e decode_ctrl(input logic [2:0] aluop,
                                        input logic [5:0] func,
                                        input logic       muldiv_en);
    ctrl_e c;
    c = CTRL_NOP;
    if (aluop[2]) begin
      c = CTRL_SUB;
    end else begin
      case (aluop[1:0])
        2'b01, 2'b10: c = CTRL_ADD;
        2'b11:        c = CTRL_AND;
        default: begin
          case (func)
            FUNC_ADD:  c = CTRL_ADD;
            FUNC_SUB:  c = CTRL_SUB;
            FUNC_AND:  c = CTRL_AND;
            FUNC_NOR:  c = CTRL_NOR;
            FUNC_SLL:  c = CTRL_SLL;
            FUNC_SLT:  c = CTRL_SLT;
            FUNC_MULT: c = muldiv_en ? CTRL_MULT : CTRL_NOP;
            FUNC_DIVU: c = muldiv_en ? CTRL_DIVU : CTRL_NOP;
            FUNC_MFHI: c = muldiv_en ? CTRL_MFHI : CTRL_NOP;
            FUNC_MFLO: c = muldiv_en ? CTRL_MFLO : CTRL_NOP;
            default:   c = CTRL_NOP;
          endcase
        end
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// rtl/mul_div_iter.sv - iterative shift-add multiplier / restoring divider
//
// Purpose : WIDTH-cycle unsigned multiply or divide engine.
// Ports   : i_clk, i_rst (async, active-high)
//           i_start   load operands and begin (i_op_div selects divide)
//           i_a, i_b  multiplicand/dividend, multiplier/divisor
//           o_busy    iterating
//           o_done    one-cycle pulse, o_hi/o_lo hold the result
//           o_hi/o_lo product {hi,lo}, or remainder/quotient
// Config  : only instantiated when ALU_MULDIV_EN is defined.
module mul_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_op_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_div;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  // Multiply: {hi,lo} starts as {0,A}; each step adds B into hi when the
  // current multiplier bit lo[0] is set, then shifts the pair right.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  // Divide: remainder in hi, dividend/quotient in lo, shifted left each step.
  // Since hi < B, the shifted remainder is below 2*B, so the borrow bit of
  // the (WIDTH+1)-bit difference is exactly "shifted < B".
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_b};
  assign w_ge    = ~w_diff[WIDTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_div  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_hi   <= '0;
        r_lo   <= i_a;
        r_b    <= i_b;
        r_div  <= i_op_div;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (r_div) begin
          if (w_ge) begin
            r_hi <= w_diff[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
          end else begin
            r_hi <= w_shift[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
          end
        end else begin
          r_hi <= w_sum[WIDTH:1];
          r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
        end
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - ALU control decoder with registered execute sequencer
//
// Purpose : Decodes Aluop/Func, executes single-cycle ops one cycle after
//           issue, and sequences iterative MULT/DIVU into Hi/Lo.
// Ports   : i_clk, i_rst (async, active-high)
//           i_valid, i_aluop, i_func, i_a, i_b, i_shamt  issue side
//           o_ready    sequencer idle
//           o_done     one-cycle result strobe
//           o_ctrl     decoded op of the last accepted issue
//           o_result, o_zero, o_illegal  registered result and flags
//           o_hi, o_lo multiply/divide result registers
// Config  : ALU_MULDIV_EN builds MULT/DIVU/MFHI/MFLO, the MUL/DIV states
//           and mul_div_iter; without it Hi/Lo are 0 and o_ready is 1.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic [2:0]               i_aluop,
  input  logic [5:0]               i_func,
  input  logic [WIDTH-1:0]         i_a,
  input  logic [WIDTH-1:0]         i_b,
  input  logic [$clog2(WIDTH)-1:0] i_shamt,
  output logic                     o_ready,
  output logic                     o_done,
  output logic [3:0]               o_ctrl,
  output logic [WIDTH-1:0]         o_result,
  output logic                     o_zero,
  output logic                     o_illegal,
  output logic [WIDTH-1:0]         o_hi,
  output logic [WIDTH-1:0]         o_lo
);

  localparam int SW = $clog2(WIDTH);

`ifdef ALU_MULDIV_EN
  localparam logic MD_EN = 1'b1;
`else
  localparam logic MD_EN = 1'b0;
`endif

  ctrl_e            w_dec;
  logic             w_issue;
  logic             w_single;
  logic [WIDTH-1:0] w_res;

  // Operands and op captured at issue; executed on the following edge.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [SW-1:0]    r_shamt;
  ctrl_e            r_op;
  logic             r_pend;

  logic             r_done;
  ctrl_e            r_ctrl;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;

  assign w_dec   = decode_ctrl(i_aluop, i_func, MD_EN);
  assign w_issue = i_valid & o_ready;

`ifdef ALU_MULDIV_EN
  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_start;
  logic             w_eng_busy;
  logic             w_eng_done;
  logic [WIDTH-1:0] w_eng_hi;
  logic [WIDTH-1:0] w_eng_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Divide by zero never enters the engine; it finishes like a single op.
  assign w_start  = w_issue &&
                    ((w_dec == CTRL_MULT) || ((w_dec == CTRL_DIVU) && (i_b != '0)));
  assign w_single = !((r_op == CTRL_MULT) || ((r_op == CTRL_DIVU) && (r_b != '0)));
  assign o_ready  = (r_state == ST_IDLE) && !w_eng_busy;
  assign o_hi     = r_hi;
  assign o_lo     = r_lo;

  mul_div_iter #(.WIDTH(WIDTH)) u_mul_div (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (w_start),
    .i_op_div (w_dec == CTRL_DIVU),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_busy   (w_eng_busy),
    .o_done   (w_eng_done),
    .o_hi     (w_eng_hi),
    .o_lo     (w_eng_lo)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = (w_dec == CTRL_DIVU) ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        if (w_eng_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end
`else
  assign w_single = 1'b1;
  assign o_ready  = 1'b1;
  assign o_hi     = '0;
  assign o_lo     = '0;
`endif

  always_comb begin
    w_res = '0;
    case (r_op)
      CTRL_ADD:  w_res = r_a + r_b;
      CTRL_SUB:  w_res = r_a - r_b;
      CTRL_AND:  w_res = r_a & r_b;
      CTRL_NOR:  w_res = ~(r_a | r_b);
      CTRL_SLL:  w_res = r_b << r_shamt;
      CTRL_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      CTRL_DIVU: w_res = '1;
      CTRL_MFHI: w_res = o_hi;
      CTRL_MFLO: w_res = o_lo;
      default:   w_res = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_shamt   <= '0;
      r_op      <= CTRL_NOP;
      r_pend    <= 1'b0;
      r_done    <= 1'b0;
      r_ctrl    <= CTRL_NOP;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
`ifdef ALU_MULDIV_EN
      r_hi      <= '0;
      r_lo      <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_pend <= w_issue;
      if (w_issue) begin
        r_a     <= i_a;
        r_b     <= i_b;
        r_shamt <= i_shamt;
        r_op    <= w_dec;
      end
      if (r_pend) begin
        r_ctrl <= r_op;
        if (w_single) begin
          r_result  <= w_res;
          r_zero    <= (w_res == '0);
          r_illegal <= (r_op == CTRL_NOP);
          r_done    <= 1'b1;
        end
      end
`ifdef ALU_MULDIV_EN
      if (r_pend && (r_op == CTRL_DIVU) && (r_b == '0)) begin
        r_hi <= r_a;
        r_lo <= '1;
      end
      if (w_eng_done) begin
        r_hi      <= w_eng_hi;
        r_lo      <= w_eng_lo;
        r_result  <= w_eng_lo;
        r_zero    <= (w_eng_lo == '0);
        r_illegal <= 1'b0;
        r_done    <= 1'b1;
      end
`endif
    end
  end

  assign o_done    = r_done;
  assign o_ctrl    = r_ctrl;
  assign o_result  = r_result;
  assign o_zero    = r_zero;
  assign o_illegal = r_illegal;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - directed self-checking bench for alu_ctrl_seq
module tb_alu_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [2:0]  aluop;
  logic [5:0]  func;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        ready;
  logic        done;
  logic [3:0]  ctrl;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  alu_ctrl_seq #(.WIDTH(32)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (valid),
    .i_aluop   (aluop),
    .i_func    (func),
    .i_a       (a),
    .i_b       (b),
    .i_shamt   (shamt),
    .o_ready   (ready),
    .o_done    (done),
    .o_ctrl    (ctrl),
    .o_result  (result),
    .o_zero    (zero),
    .o_illegal (illegal),
    .o_hi      (hi),
    .o_lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [5:0] f,
                       input logic [31:0] xa, input logic [31:0] xb, input logic [4:0] sh);
    aluop = op; func = f; a = xa; b = xb; shamt = sh; valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic single(input string tag, input logic [2:0] op, input logic [5:0] f,
                        input logic [31:0] xa, input logic [31:0] xb, input logic [4:0] sh,
                        input logic [31:0] er, input logic ez, input logic [3:0] ec,
                        input logic ei);
    issue(op, f, xa, xb, sh);
    chk({tag, "_nodone_yet"}, done, 1'b0);
    chk({tag, "_ready_kept"}, ready, 1'b1);
    tick();
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_result"}, result, er);
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_ctrl"}, ctrl, ec);
    chk({tag, "_illegal"}, illegal, ei);
  endtask

  initial begin
    int early;
    rst = 1'b1; valid = 1'b0; aluop = 3'b000; func = 6'b0;
    a = '0; b = '0; shamt = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_ctrl", ctrl, 4'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);

    single("add", 3'b000, 6'b100000, 32'd7, 32'd5, 5'd0, 32'd12, 1'b0, 4'd1, 1'b0);
    tick();
    chk("add_pulse_end", done, 1'b0);
    chk("add_result_hold", result, 32'd12);

    single("beq", 3'b100, 6'b000000, 32'h1234, 32'h1234, 5'd0, 32'h0, 1'b1, 4'd2, 1'b0);
    single("lw", 3'b001, 6'b111111, 32'd10, 32'd20, 5'd0, 32'd30, 1'b0, 4'd1, 1'b0);
    single("andi", 3'b011, 6'b100000, 32'hF0F0, 32'h0FF0, 5'd0, 32'h00F0, 1'b0, 4'd3, 1'b0);
    single("sll", 3'b000, 6'b000000, 32'hFFFF, 32'h3, 5'd4, 32'h30, 1'b0, 4'd5, 1'b0);
    single("sll_max", 3'b000, 6'b000000, 32'h0, 32'h3, 5'd31, 32'h80000000, 1'b0, 4'd5, 1'b0);
    single("slt_neg", 3'b000, 6'b101010, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 1'b0, 4'd6, 1'b0);
    single("slt_pos", 3'b000, 6'b101010, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b1, 4'd6, 1'b0);
    single("nor", 3'b000, 6'b100111, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0, 4'd4, 1'b0);
    single("add_wrap", 3'b000, 6'b100000, 32'hFFFFFFFF, 32'd1, 5'd0, 32'h0, 1'b1, 4'd1, 1'b0);
    single("illegal", 3'b000, 6'b111111, 32'd3, 32'd4, 5'd0, 32'h0, 1'b1, 4'd0, 1'b1);

    // Back-to-back: second issue lands on the first op's Done cycle.
    aluop = 3'b000; func = 6'b100010; a = 32'd5; b = 32'd7; valid = 1'b1;
    tick();
    func = 6'b100100; a = 32'hF0F0; b = 32'hFF00;
    tick();
    valid = 1'b0;
    chk("b2b_sub_done", done, 1'b1);
    chk("b2b_sub_result", result, 32'hFFFFFFFE);
    chk("b2b_sub_ctrl", ctrl, 4'd2);
    tick();
    chk("b2b_and_done", done, 1'b1);
    chk("b2b_and_result", result, 32'hF000);
    chk("b2b_and_ctrl", ctrl, 4'd3);
    tick();
    chk("b2b_idle", done, 1'b0);

`ifdef ALU_MULDIV_EN
    // MULT 0xFFFFFFFF * 2 with ignored Valid pulses while busy.
    issue(3'b000, 6'b011000, 32'hFFFFFFFF, 32'd2, 5'd0);
    chk("mult_busy", ready, 1'b0);
    early = 0;
    for (int k = 1; k <= 32; k++) begin
      valid = (k == 5 || k == 10);
      func  = 6'b100000;
      tick();
      if (done) early++;
    end
    valid = 1'b0;
    chk("mult_no_early_done", early, 0);
    chk("mult_busy_late", ready, 1'b0);
    tick();
    chk("mult_done", done, 1'b1);
    chk("mult_hi", hi, 32'd1);
    chk("mult_lo", lo, 32'hFFFFFFFE);
    chk("mult_result", result, 32'hFFFFFFFE);
    chk("mult_ready", ready, 1'b1);
    chk("mult_ctrl", ctrl, 4'd7);
    tick();
    chk("mult_valid_ignored", done, 1'b0);

    // DIVU 100 / 7, then MFHI issued on the Done cycle.
    issue(3'b000, 6'b011010, 32'd100, 32'd7, 5'd0);
    repeat (32) tick();
    chk("divu_not_yet", done, 1'b0);
    tick();
    chk("divu_done", done, 1'b1);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    chk("divu_result", result, 32'd14);
    single("mfhi", 3'b000, 6'b010000, 32'd0, 32'd0, 5'd0, 32'd2, 1'b0, 4'd9, 1'b0);
    single("mflo", 3'b000, 6'b010010, 32'd0, 32'd0, 5'd0, 32'd14, 1'b0, 4'd10, 1'b0);

    single("div0", 3'b000, 6'b011010, 32'd9, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 4'd8, 1'b0);
    chk("div0_lo", lo, 32'hFFFFFFFF);
    chk("div0_hi", hi, 32'd9);

    // Reset in the middle of a MULT.
    issue(3'b000, 6'b011000, 32'd3, 32'd5, 5'd0);
    repeat (10) tick();
    rst = 1'b1;
    #2;
    chk("mrst_hi", hi, 32'h0);
    chk("mrst_lo", lo, 32'h0);
    chk("mrst_ready", ready, 1'b1);
    tick();
    rst = 1'b0;
    early = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) early++;
    end
    chk("mrst_no_done", early, 0);
    chk("mrst_hi_after", hi, 32'h0);
    chk("mrst_lo_after", lo, 32'h0);
`else
    single("mult_off", 3'b000, 6'b011000, 32'hFFFFFFFF, 32'd2, 5'd0, 32'h0, 1'b1, 4'd0, 1'b1);
    chk("mult_off_hi", hi, 32'h0);
    chk("mult_off_lo", lo, 32'h0);
    single("divu_off", 3'b000, 6'b011010, 32'd9, 32'd0, 5'd0, 32'h0, 1'b1, 4'd0, 1'b1);
    single("mfhi_off", 3'b000, 6'b010000, 32'd1, 32'd1, 5'd0, 32'h0, 1'b1, 4'd0, 1'b1);
    single("mflo_off", 3'b000, 6'b010010, 32'd1, 32'd1, 5'd0, 32'h0, 1'b1, 4'd0, 1'b1);
    chk("off_ready", ready, 1'b1);

    // Reset between issue and Done drops the pending op.
    single("pre_rst", 3'b000, 6'b100000, 32'd1, 32'd2, 5'd0, 32'd3, 1'b0, 4'd1, 1'b0);
    issue(3'b000, 6'b100000, 32'd40, 32'd2, 5'd0);
    rst = 1'b1;
    #2;
    chk("arst_result", result, 32'h0);
    chk("arst_ready", ready, 1'b1);
    tick();
    rst = 1'b0;
    early = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done) early++;
    end
    chk("arst_no_done", early, 0);
    chk("arst_ctrl", ctrl, 4'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
